tt_pll_loop_ctrl: RTL
=====================

Name: tt_pll_loop_ctrl

Overview:
Digital loop-filter and lock controller for the on-chip all-digital PLL. It consumes the single-cycle o_up/o_down pulses from the phase-frequency detector (PFD) and integrates them into the DCO control word. It also sequences coarse acquisition, fine tracking and lock detection. It sits between the PFD and the DCO, and is on the same scan chain.

Parameters:
CTRL_W, 8, DCO control word width (min 4)
INIT_CODE, 8'h80, control word loaded at reset, disable and restart
COARSE_STEP, 4, control word step per pulse in ACQUIRE
WIN, 16, evaluation window length in i_clk cycles (power of 2)
LOCK_THRESH, 2, max |net error| for a window to count as quiet
LOCK_WINS, 4, consecutive quiet windows needed to declare lock
UNLOCK_THRESH, 6, |net error| in one window that drops lock

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  loop enable
i_up  in  1  PFD up pulse (ref leads)
i_down  in  1  PFD down pulse (fb leads)
o_ctrl  out  CTRL_W  DCO control word (registered)
o_locked  out  1  high while state is LOCKED
o_state  out  2  current state encoding
o_sat  out  1  one-cycle pulse after a clamped update
i_scan_en  in  1  scan shift enable
i_scan_in  in  1  scan data in
o_scan_out  out  1  scan data out, equal to o_ctrl[CTRL_W-1]

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values: state IDLE, o_ctrl=INIT_CODE, o_locked=0, o_sat=0. Window, net-error and quiet counters are 0. The last-direction valid flag is 0.
- Priority order: reset > i_scan_en > !i_en > functional update.
- Scan (i_scan_en=1):
  - o_ctrl <= {o_ctrl[CTRL_W-2:0], i_scan_in}.
  - All other registers hold, and o_sat=0.
- Disable (i_en=0): the next state is IDLE, o_ctrl reloads INIT_CODE, all counters and flags clear, and o_locked=0.
- States: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3. o_locked is registered and equals (state==LOCKED).
- IDLE: o_ctrl holds. If i_en=1, go to ACQUIRE next cycle.
- Per-cycle update in ACQUIRE, TRACK and LOCKED:
  - up&&!down: o_ctrl += step.
  - down&&!up: o_ctrl -= step.
  - Both or neither: no change.
  - step = COARSE_STEP in ACQUIRE, 1 otherwise.
- Saturation:
  - The result clamps to [0, 2^CTRL_W-1].
  - A clamp sets o_sat=1 for the next cycle.
  - A clamp in TRACK or LOCKED forces ACQUIRE next, and clears the window, net and quiet counters.
- ACQUIRE exit:
  - On a polarity reversal (a pulse opposite to the last recorded pulse, with the valid flag set), go to TRACK next cycle.
  - The reversing pulse still applies the coarse step.
  - The last-direction flag updates on every single-direction pulse.
- Window logic:
  - The window counter runs 0..WIN-1 in TRACK and LOCKED, and wraps.
  - The net counter is signed, width clog2(WIN)+2: +1 per up-only cycle, -1 per down-only cycle.
  - The window-end cycle's own pulse is included in the evaluation.
  - Net clears at window end.
- TRACK, at window end:
  - |net|<=LOCK_THRESH: quiet++.
  - Otherwise: quiet=0.
  - When quiet reaches LOCK_WINS, go to LOCKED.
- LOCKED, at window end: if |net|>=UNLOCK_THRESH, go to TRACK and set quiet=0.
- Simultaneous events: a saturation restart beats a window-end transition.

Decomposition:
- Package tt_pll_pkg: enum pll_state_e {IDLE, ACQUIRE, TRACK, LOCKED} as logic[1:0], and default constant PLL_CTRL_W=8.
- Sub-module tt_pll_lock_det: window counter, net counter and quiet counter.
  - Outputs: win_end, quiet_win, loud_win, lock_ok.
  - Input: clear.

Test Plan:
- Reset/enable: assert reset → o_ctrl=0x80, o_state=0, o_locked=0. Set i_en=1 → o_state=1 the next cycle.
- Acquire: 3 up pulses → o_ctrl=0x8C. Then 1 down pulse → o_ctrl=0x88 and o_state=2 the next cycle.
- Lock: in TRACK, no pulses for 64 cycles → o_state=3 and o_locked=1 after the 4th window end. o_ctrl stays 0x88.
- Unlock: in LOCKED, 6 up pulses within one window → o_ctrl=0x8E, and o_state=2 after that window end. o_locked=0.
- Saturation:
  - o_ctrl=0xFE in ACQUIRE, up pulse → o_ctrl=0xFF and o_sat pulses for 1 cycle.
  - In TRACK at 0xFF, up pulse → o_ctrl=0xFF, o_sat=1, o_state=1.
- Scan/disable:
  - From reset, i_scan_en=1 for 8 cycles shifting 0xA5 MSB-first → o_ctrl=0xA5. o_scan_out emits 1,0,0,0,0,0,0,0 and the state is unchanged.
  - Then i_en=0 → o_ctrl=0x80 and o_state=0.

Source files
------------

// File: rtl/tt_pll_pkg.sv
// Shared types and constants for the all-digital PLL loop controller.
//   pll_state_e : loop controller state, encoding visible on o_state
//   PLL_CTRL_W  : default DCO control word width
package tt_pll_pkg;

   localparam int PLL_CTRL_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      LOCKED  = 2'd3
   } pll_state_e;

endpackage

// File: rtl/tt_pll_lock_det.sv
// Lock detector for the PLL loop controller: window counter, signed net
// phase-error counter and consecutive-quiet-window counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   clear          : zero all three counters next cycle (highest priority)
//   run            : advance the window and accumulate net error this cycle
//   track_mode     : window ends count quiet windows (TRACK) instead of
//                    watching for loud ones (LOCKED)
//   up, down       : PFD pulses of this cycle
//   win_end        : this cycle is the last of the evaluation window
//   quiet_win      : |net| including this cycle's pulse is <= LOCK_THRESH
//   loud_win       : |net| including this cycle's pulse is >= UNLOCK_THRESH
//   lock_ok        : window end that brings the quiet count to LOCK_WINS
// The status outputs are not gated by run; the controller qualifies them
// with its own state so no combinational path runs back through run.
module tt_pll_lock_det #(
   parameter int WIN           = 16,
   parameter int LOCK_THRESH   = 2,
   parameter int LOCK_WINS     = 4,
   parameter int UNLOCK_THRESH = 6
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic clear,
   input  logic run,
   input  logic track_mode,
   input  logic up,
   input  logic down,
   output logic win_end,
   output logic quiet_win,
   output logic loud_win,
   output logic lock_ok
);

   localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int NET_W = $clog2(WIN) + 2;
   localparam int Q_W   = $clog2(LOCK_WINS + 1);

   localparam logic [NET_W-1:0] NET_ONE = NET_W'(1);

   logic [WIN_W-1:0]        win_cnt;
   logic signed [NET_W-1:0] net;
   logic signed [NET_W-1:0] net_eval;
   logic [NET_W-1:0]        net_abs;
   logic [Q_W-1:0]          quiet;
   logic [Q_W-1:0]          quiet_inc;

   // Net error with this cycle's pulse folded in, so the window-end
   // cycle's own pulse takes part in the evaluation.
   always_comb begin
      net_eval = net;
      if (up && !down) begin
         net_eval = net + NET_ONE;
      end else if (down && !up) begin
         net_eval = net - NET_ONE;
      end
   end

   assign net_abs   = net_eval[NET_W-1] ? NET_W'(-net_eval) : NET_W'(net_eval);
   assign win_end   = (win_cnt == WIN_W'(WIN - 1));
   assign quiet_win = (net_abs <= NET_W'(LOCK_THRESH));
   assign loud_win  = (net_abs >= NET_W'(UNLOCK_THRESH));
   assign quiet_inc = quiet + Q_W'(1);
   assign lock_ok   = win_end && quiet_win && (quiet_inc >= Q_W'(LOCK_WINS));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         win_cnt <= '0;
         net     <= '0;
         quiet   <= '0;
      end else if (clear) begin
         win_cnt <= '0;
         net     <= '0;
         quiet   <= '0;
      end else if (run) begin
         if (win_end) begin
            win_cnt <= '0;
            net     <= '0;
            if (track_mode) begin
               quiet <= quiet_win ? quiet_inc : '0;
            end else if (loud_win) begin
               quiet <= '0;
            end
         end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            net     <= net_eval;
         end
      end
   end

endmodule

// File: rtl/tt_pll_loop_ctrl.sv
// Digital loop filter and lock controller for the all-digital PLL.
// Integrates PFD up/down pulses into the DCO control word, sequencing
// IDLE -> ACQUIRE (coarse steps) -> TRACK (unit steps) -> LOCKED.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_en                  : loop enable; low returns to IDLE at INIT_CODE
//   i_up, i_down          : PFD pulses (ref leads / fb leads)
//   o_ctrl                : registered DCO control word
//   o_locked              : registered, high while state is LOCKED
//   o_state               : current state encoding (pll_state_e)
//   o_sat                 : one-cycle pulse after a clamped update
//   i_scan_en, i_scan_in  : scan shift through o_ctrl, MSB out first
//   o_scan_out            : o_ctrl MSB
module tt_pll_loop_ctrl
   import tt_pll_pkg::*;
#(
   parameter int                CTRL_W        = PLL_CTRL_W,
   parameter logic [CTRL_W-1:0] INIT_CODE     = 8'h80,
   parameter int                COARSE_STEP   = 4,
   parameter int                WIN           = 16,
   parameter int                LOCK_THRESH   = 2,
   parameter int                LOCK_WINS     = 4,
   parameter int                UNLOCK_THRESH = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_up,
   input  logic              i_down,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic              o_locked,
   output logic [1:0]        o_state,
   output logic              o_sat,
   input  logic              i_scan_en,
   input  logic              i_scan_in,
   output logic              o_scan_out
);

   pll_state_e        state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              locked_q;
   logic              sat_q, sat_d;
   logic              last_up_q, last_up_d;
   logic              last_vld_q, last_vld_d;

   logic              up_only, dn_only;
   logic [CTRL_W:0]   step;
   logic [CTRL_W:0]   sum_up;
   logic [CTRL_W-1:0] diff_dn;
   logic              over, under, clamp, reversal;

   logic              det_clear, det_run, det_track;
   logic              win_end, quiet_win, loud_win, lock_ok;

   assign up_only = i_up && !i_down;
   assign dn_only = i_down && !i_up;
   assign step    = (state_q == ACQUIRE) ? (CTRL_W+1)'(COARSE_STEP) : (CTRL_W+1)'(1);

   // One extra bit exposes overflow above 2^CTRL_W-1; underflow is a
   // plain compare against the step.
   assign sum_up  = {1'b0, ctrl_q} + step;
   assign diff_dn = ctrl_q - step[CTRL_W-1:0];
   assign over    = sum_up[CTRL_W];
   assign under   = ({1'b0, ctrl_q} < step);
   assign clamp   = (up_only && over) || (dn_only && under);

   // A reversal needs a previously recorded direction to compare with.
   assign reversal = last_vld_q && ((up_only && !last_up_q) || (dn_only && last_up_q));

   assign det_track = (state_q == TRACK);

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      sat_d      = 1'b0;
      last_up_d  = last_up_q;
      last_vld_d = last_vld_q;
      det_clear  = 1'b0;
      det_run    = 1'b0;

      if (i_scan_en) begin
         ctrl_d = {ctrl_q[CTRL_W-2:0], i_scan_in};
      end else if (!i_en) begin
         state_d    = IDLE;
         ctrl_d     = INIT_CODE;
         last_up_d  = 1'b0;
         last_vld_d = 1'b0;
         det_clear  = 1'b1;
      end else if (state_q == IDLE) begin
         state_d   = ACQUIRE;
         det_clear = 1'b1;
      end else begin
         if (up_only) begin
            ctrl_d = over ? '1 : sum_up[CTRL_W-1:0];
         end else if (dn_only) begin
            ctrl_d = under ? '0 : diff_dn;
         end
         sat_d = clamp;

         if (up_only || dn_only) begin
            last_up_d  = up_only;
            last_vld_d = 1'b1;
         end

         if (state_q == ACQUIRE) begin
            // Window counters only run once tracking; hold them at zero.
            det_clear = 1'b1;
            if (reversal) begin
               state_d = TRACK;
            end
         end else if (clamp) begin
            // Saturation restart outranks any window-end transition.
            state_d   = ACQUIRE;
            det_clear = 1'b1;
         end else begin
            det_run = 1'b1;
            if (state_q == TRACK) begin
               if (win_end && quiet_win && lock_ok) begin
                  state_d = LOCKED;
               end
            end else if (win_end && loud_win) begin
               state_d = TRACK;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         ctrl_q     <= INIT_CODE;
         locked_q   <= 1'b0;
         sat_q      <= 1'b0;
         last_up_q  <= 1'b0;
         last_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         locked_q   <= (state_d == LOCKED);
         sat_q      <= sat_d;
         last_up_q  <= last_up_d;
         last_vld_q <= last_vld_d;
      end
   end

   tt_pll_lock_det #(
      .WIN           (WIN),
      .LOCK_THRESH   (LOCK_THRESH),
      .LOCK_WINS     (LOCK_WINS),
      .UNLOCK_THRESH (UNLOCK_THRESH)
   ) u_lock_det (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .clear      (det_clear),
      .run        (det_run),
      .track_mode (det_track),
      .up         (i_up),
      .down       (i_down),
      .win_end    (win_end),
      .quiet_win  (quiet_win),
      .loud_win   (loud_win),
      .lock_ok    (lock_ok)
   );

   assign o_ctrl     = ctrl_q;
   assign o_locked   = locked_q;
   assign o_state    = state_q;
   assign o_sat      = sat_q;
   assign o_scan_out = ctrl_q[CTRL_W-1];

endmodule
